fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly upstream of `InstructionMemory`. It owns the program counter and drives `imem_addr` into the memory's combinational read port. It registers the returned `imem_instr` into an IF/ID output register with a valid/ready handshake towards decode. It also handles branch/jump redirects, flushing, halting and misaligned-target faults.

## Interface
- `DATA_WIDTH`, 32, instruction width
- `ADDR_WIDTH`, 32, PC/address width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `imem_addr`  out  ADDR_WIDTH  address to `InstructionMemory.pc_address`; equals the PC register, combinational
- `imem_instr`  in  DATA_WIDTH  instruction returned combinationally by memory
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_target`  in  ADDR_WIDTH  new PC when `redirect_valid`
- `halt_req`  in  1  stop fetching while high
- `id_ready`  in  1  decode accepts the output register this cycle
- `id_valid`  out  1  output register holds a valid instruction
- `id_instr`  out  DATA_WIDTH  registered instruction
- `id_pc`  out  ADDR_WIDTH  PC of `id_instr`
- `fault`  out  1  sticky misaligned-redirect flag

## Operation
- **States:** RUN, HALT, FAULT. Reset state is RUN.
- **Load condition:** `load = !id_valid || id_ready`, i.e. the output register is empty or is being consumed.
- **Priority each edge:** FAULT > redirect > halt > load > hold.
- **Misaligned redirect:** `redirect_valid` with `redirect_target[1:0] != 0`, in any state other than FAULT, causes:
  - next state FAULT, `fault` = 1, `id_valid` = 0;
  - `pc` = `redirect_target` (kept for debug).
- **Aligned redirect:** `id_valid` = 0 (flush), `pc` = `redirect_target`. The state is unchanged (RUN stays RUN, HALT stays HALT). The instruction at the old PC is discarded.
- **RUN, no redirect, `halt_req` = 1:** next state HALT. No load occurs that cycle. If `id_ready` is high, `id_valid` clears.
- **RUN, no redirect, `load`:**
  - `id_instr` = `imem_instr`, `id_pc` = `pc`, `id_valid` = 1;
  - `pc` = `pc` + 4.
- **RUN, no `load` (decode stalls):** `pc` and the output register hold.
- **HALT:**
  - No loads occur. `id_valid` clears once `id_ready` is seen.
  - When `halt_req` = 0, return to RUN; fetching resumes from the held `pc` on the following edge.
- **FAULT:** terminal until `rst`.
  - `id_valid` = 0, `pc` frozen.
  - `redirect_valid`, `halt_req` and `id_ready` are all ignored.
- **Arithmetic:** `pc` + 4 is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC wraps to 32'h0000_0000. The block does not check the address against the memory size.

## Timing
- **Reset values (`rst` high, asynchronous):**
  - `pc` = RESET_PC, so `imem_addr` = RESET_PC immediately;
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0, `fault` = 0;
  - state RUN.
- Reset asserted mid-operation clears everything above immediately; no partial transfer survives.
- **Latency:** 1 cycle from `imem_addr` = A to `id_instr` = mem[A] with `id_valid` high.
- **Throughput:** 1 instruction/cycle while `id_ready` is held high.
- **First fetch after reset release:** the first rising edge with `rst` low loads mem[RESET_PC].
- **Redirect:** issued at edge N, the instruction at the target is valid on `id_instr` after edge N+1. This is a 1-bubble penalty.
- **Stall:** while `id_valid` = 1 and `id_ready` = 0, `id_*` and `imem_addr` are stable.
- **Simultaneous redirect + `id_ready`:** the current output is consumed and the register flushes. No instruction is lost or duplicated.
- **Simultaneous redirect + `halt_req` in RUN:** the redirect wins for that edge. HALT is entered on the next edge if `halt_req` is still high.

## Structure
- Shared package/header `fetch_pkg` holds:
  - state encodings `FETCH_RUN`, `FETCH_HALT`, `FETCH_FAULT`;
  - `INSTR_BYTES` = 4;
  - the default `RESET_PC`.
- Natural sub-module `fetch_pc_reg`: the PC register with async reset, increment, redirect-load and hold.
- The state machine and the IF/ID output register stay in `fetch_unit`.
- A top-level bench instantiates `fetch_unit` together with `InstructionMemory` preloaded with known words.

## Test plan
- **Reset and stream:** memory words 0..3 = 32'h11111111, 22222222, 33333333, 44444444, `id_ready` = 1 → `id_valid` rises 1 cycle after reset release; `id_pc` = 0, 4, 8, 12 on consecutive cycles with the matching instructions.
- **Stall:** drop `id_ready` for 3 cycles while `id_pc` = 4 → `id_instr` holds 32'h22222222 and `imem_addr` holds 8; on release the next `id_pc` = 8.
- **Redirect:** `redirect_valid` = 1, target 32'h0000_0040, at the edge where `id_pc` = 4 → one cycle with `id_valid` = 0, then `id_pc` = 32'h40; addresses 8 and 12 never appear.
- **Halt:** assert `halt_req` for 4 cycles at PC 8 → `id_valid` drops and no new `id_pc` appears; after release `id_pc` = 8 resumes.
- **Misaligned redirect:** target 32'h0000_0042 → `fault` = 1 on the next edge, `id_valid` stays 0, and an aligned redirect is ignored; only `rst` clears `fault` and `pc` returns to 0.
- **Wrap and mid-run reset:** redirect to 32'hFFFF_FFFC → next `imem_addr` = 0. Asserting `rst` between edges → outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned FETCH_ADDR_W     = 32;
    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_HALT  = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_e;

    // Targets must be word aligned; low two bits flag a bad branch/jump.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port plus the IF/ID handshake.
interface fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  halt_req;
    logic                  id_ready;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic                  fault;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, fault,
        input  imem_instr, redirect_valid, redirect_target, halt_req, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, fault,
        output imem_instr, redirect_valid, redirect_target, halt_req, id_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: increment by one instruction, load a target, or hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  pc_op_e                op_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Increment wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        unique case (op_i)
            PC_INC:  pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            PC_LOAD: pc_d = target_i;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fills the IF/ID register, and handles
// redirects, halting and sticky misaligned-target faults.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    fetch_state_e          state_q, state_d;
    logic                  id_valid_q, id_valid_d;
    logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
    logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
    logic                  fault_q, fault_d;
    pc_op_e                pc_op;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  load;

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .op_i     (pc_op),
        .target_i (bus.redirect_target),
        .pc_o     (pc)
    );

    assign load = !id_valid_q || bus.id_ready;

    // Priority: fault > redirect > halt > load > hold.
    always_comb begin
        state_d    = state_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        fault_d    = fault_q;
        pc_op      = PC_HOLD;

        unique case (state_q)
            FETCH_FAULT: begin
                id_valid_d = 1'b0;
            end
            default: begin
                if (bus.redirect_valid) begin
                    id_valid_d = 1'b0;
                    pc_op      = PC_LOAD;
                    if (is_misaligned(bus.redirect_target[1:0])) begin
                        state_d = FETCH_FAULT;
                        fault_d = 1'b1;
                    end
                end else if (state_q == FETCH_RUN) begin
                    if (bus.halt_req) begin
                        state_d = FETCH_HALT;
                        if (bus.id_ready) id_valid_d = 1'b0;
                    end else if (load) begin
                        id_valid_d = 1'b1;
                        id_instr_d = bus.imem_instr;
                        id_pc_d    = pc;
                        pc_op      = PC_INC;
                    end
                end else begin
                    // Halted: drain the output register, resume one edge after release.
                    if (bus.id_ready) id_valid_d = 1'b0;
                    if (!bus.halt_req) state_d = FETCH_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_RUN;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.fault     = fault_q;

endmodule
